// File: rtl/thread_state_mc_pkg.sv
// Shared constants for the thread-state table: state encodings, the state
// width used by the engine build, and an MSB helper for index sizing.
package thread_state_mc_pkg;

  localparam int THREAD_STATE_MSB = 1;

  typedef enum logic [THREAD_STATE_MSB:0] {
    THREAD_STATE_NONE = 2'd0,
    THREAD_STATE_WR   = 2'd1,
    THREAD_STATE_RDY  = 2'd2,
    THREAD_STATE_BUSY = 2'd3
  } thread_state_e;

  // Index of the highest set bit; msb(0) is 0 so a 1-thread index is 1 bit.
  function automatic int msb(input int value);
    int result;
    result = 0;
    for (int b = 0; b < 31; b++) begin
      if (value[b]) result = b;
    end
    return result;
  endfunction

endpackage

// File: rtl/thread_state_mc_rr_pick_first.sv
// Rotating priority encoder: returns the first set request strictly after
// 'last', wrapping past N-1 back to 0.
module rr_pick_first #(
  parameter int N  = 6,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_mask;
  logic [2*N-1:0] w_cand;

  // The doubled vector turns the wrap into a plain window [last+1, last+N].
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    found  = 1'b0;
    idx    = '0;
    w_dbl  = {req, req};
    w_mask = '0;
    for (int j = 0; j < 2 * N; j++) begin
      w_mask[j] = (j > int'(last)) && (j <= int'(last) + N);
    end
    w_cand = w_dbl & w_mask;
    // Descending sweep: the last assignment is the lowest candidate.
    for (int j = 2 * N - 1; j >= 0; j--) begin
      if (w_cand[j]) begin
        found = 1'b1;
        idx   = (j >= N) ? IW'(j - N) : IW'(j);
      end
    end
  end

endmodule

// File: rtl/thread_state_mc.sv
// Multi-channel thread-state table with priority-resolved writes,
// asynchronous reads and a round-robin scan-and-claim port.
module thread_state_mc
  import thread_state_mc_pkg::*;
#(
  parameter int                     N_THREADS     = 6,
  parameter int                     N_THREADS_MSB = msb(N_THREADS - 1),
  parameter int                     N_CH          = 4,
  parameter int                     STATE_WIDTH   = THREAD_STATE_MSB + 1,
  parameter logic [STATE_WIDTH-1:0] STATE_RESET   = '0
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [N_CH-1:0]                     wr_en,
  input  logic [N_CH*(N_THREADS_MSB+1)-1:0]   wr_num,
  input  logic [N_CH*STATE_WIDTH-1:0]         wr_state,
  input  logic [N_CH*(N_THREADS_MSB+1)-1:0]   rd_num,
  output logic [N_CH*STATE_WIDTH-1:0]         rd_state,
  input  logic                                scan_en,
  input  logic [STATE_WIDTH-1:0]              scan_state,
  input  logic [STATE_WIDTH-1:0]              claim_state,
  output logic                                scan_valid,
  output logic [N_THREADS_MSB:0]              scan_num,
  output logic [N_THREADS_MSB+1:0]            cnt_match,
  output logic [1:0]                          err
);

  localparam int IW = N_THREADS_MSB + 1;
  localparam int CW = N_THREADS_MSB + 2;

  logic [STATE_WIDTH-1:0] r_table [N_THREADS];
  logic [IW-1:0]          r_rr_last;
  logic                   r_scan_valid;
  logic [IW-1:0]          r_scan_num;
  logic [CW-1:0]          r_cnt_match;
  logic [1:0]             r_err;

  logic [N_THREADS-1:0]   w_wr_hit;
  logic [STATE_WIDTH-1:0] w_wr_val [N_THREADS];
  logic                   w_wr_collide;
  logic [N_THREADS-1:0]   w_match;
  logic                   w_found;
  logic [IW-1:0]          w_pick;
  logic                   w_claim;
  logic                   w_claim_collide;
  logic [CW-1:0]          w_cnt;

  always_comb begin
    rd_state = '0;
    for (int k = 0; k < N_CH; k++) begin
      for (int i = 0; i < N_THREADS; i++) begin
        if (rd_num[k*IW +: IW] == IW'(i)) begin
          rd_state[k*STATE_WIDTH +: STATE_WIDTH] = r_table[i];
        end
      end
    end
  end

  // Channels are visited in ascending order so the lowest index claims a
  // thread first; any later hit on it, or an out-of-range index, collides.
  always_comb begin
    logic in_range;
    w_wr_hit     = '0;
    w_wr_collide = 1'b0;
    in_range     = 1'b0;
    for (int i = 0; i < N_THREADS; i++) w_wr_val[i] = '0;
    for (int k = 0; k < N_CH; k++) begin
      in_range = 1'b0;
      for (int i = 0; i < N_THREADS; i++) begin
        if (wr_en[k] && (wr_num[k*IW +: IW] == IW'(i))) begin
          in_range = 1'b1;
          if (w_wr_hit[i]) begin
            w_wr_collide = 1'b1;
          end else begin
            w_wr_hit[i] = 1'b1;
            w_wr_val[i] = wr_state[k*STATE_WIDTH +: STATE_WIDTH];
          end
        end
      end
      if (wr_en[k] && !in_range) w_wr_collide = 1'b1;
    end
  end

  always_comb begin
    w_match = '0;
    w_cnt   = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      w_match[i] = (r_table[i] == scan_state);
      w_cnt      = w_cnt + CW'(w_match[i]);
    end
  end

  rr_pick_first #(
    .N  (N_THREADS),
    .IW (IW)
  ) u_pick (
    .req   (w_match),
    .last  (r_rr_last),
    .found (w_found),
    .idx   (w_pick)
  );

  assign w_claim = scan_en & w_found;

  always_comb begin
    w_claim_collide = 1'b0;
    for (int i = 0; i < N_THREADS; i++) begin
      if (w_claim && (w_pick == IW'(i)) && w_wr_hit[i]) w_claim_collide = 1'b1;
    end
  end

  // Channel writes outrank the claim; the grant still reports valid.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the table is reset on purpose: every thread must start in
      // STATE_RESET, so it is built from flops rather than a RAM macro.
      for (int i = 0; i < N_THREADS; i++) r_table[i] <= STATE_RESET;
      r_rr_last    <= IW'(N_THREADS - 1);
      r_scan_valid <= 1'b0;
      r_scan_num   <= '0;
      r_cnt_match  <= '0;
      r_err        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge table, which is what the scan and reads are defined on.
      for (int i = 0; i < N_THREADS; i++) begin
        if (w_wr_hit[i]) begin
          r_table[i] <= w_wr_val[i];
        end else if (w_claim && (w_pick == IW'(i))) begin
          r_table[i] <= claim_state;
        end
      end
      r_scan_valid <= w_claim;
      if (w_claim) begin
        r_scan_num <= w_pick;
        r_rr_last  <= w_pick;
      end
      r_cnt_match <= w_cnt;
      r_err       <= r_err | {w_claim_collide, w_wr_collide};
    end
  end

  assign scan_valid = r_scan_valid;
  assign scan_num   = r_scan_num;
  assign cnt_match  = r_cnt_match;
  assign err        = r_err;

endmodule

// File: tb/tb_thread_state_mc.sv
// Directed bench for thread_state_mc: 6 threads, 4 channels, 2-bit states.
module tb_thread_state_mc;

  localparam int NT = 6;
  localparam int IW = 3;
  localparam int SW = 2;
  localparam int NC = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [NC-1:0]    wr_en;
  logic [NC*IW-1:0] wr_num;
  logic [NC*SW-1:0] wr_state;
  logic [NC*IW-1:0] rd_num;
  logic [NC*SW-1:0] rd_state;
  logic          scan_en;
  logic [SW-1:0] scan_state;
  logic [SW-1:0] claim_state;
  logic          scan_valid;
  logic [IW-1:0] scan_num;
  logic [IW:0]   cnt_match;
  logic [1:0]    err;

  int n_checks = 0;
  int n_errors = 0;

  thread_state_mc #(
    .N_THREADS   (NT),
    .N_CH        (NC),
    .STATE_WIDTH (SW),
    .STATE_RESET (2'd0)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .wr_en       (wr_en),
    .wr_num      (wr_num),
    .wr_state    (wr_state),
    .rd_num      (rd_num),
    .rd_state    (rd_state),
    .scan_en     (scan_en),
    .scan_state  (scan_state),
    .claim_state (claim_state),
    .scan_valid  (scan_valid),
    .scan_num    (scan_num),
    .cnt_match   (cnt_match),
    .err         (err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_num   = '0;
    wr_state = '0;
    scan_en  = 1'b0;
  endtask

  task automatic set_wr(input int k, input int t, input int s);
    wr_en[k]            = 1'b1;
    wr_num[k*IW +: IW]  = IW'(t);
    wr_state[k*SW +: SW] = SW'(s);
  endtask

  task automatic read_thread(input int t, output logic [SW-1:0] v);
    rd_num[IW-1:0] = IW'(t);
    #1;
    v = rd_state[SW-1:0];
  endtask

  task automatic do_reset();
    idle();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [SW-1:0] v;
    idle();
    scan_state  = 2'd0;
    claim_state = 2'd0;
    rd_num      = '0;
    do_reset();
    rd_num = {3'd3, 3'd2, 3'd1, 3'd0};
    #1;
    n_checks++;
    if (rd_state !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_rd_state: got %h expected 00", rd_state);
    end
    n_checks++;
    if (err !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_err: got %b expected 00", err);
    end
    n_checks++;
    if (scan_valid !== 1'b0 || scan_num !== 3'd0 || cnt_match !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_scan_regs: got valid=%b num=%0d cnt=%0d expected 0/0/0",
               scan_valid, scan_num, cnt_match);
    end
    tick();
    n_checks++;
    if (cnt_match !== 4'd6) begin
      n_errors++;
      $display("FAIL reset_cnt_all: got %0d expected 6", cnt_match);
    end
    read_thread(5, v);
    n_checks++;
    if (v !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_thread5: got %0d expected 0", v);
    end
  endtask

  task automatic test_write_read();
    logic [SW-1:0] v;
    do_reset();
    set_wr(0, 0, 1);
    set_wr(1, 5, 2);
    set_wr(2, 3, 3);
    set_wr(3, 7, 1);
    read_thread(0, v);
    n_checks++;
    if (v !== 2'd0) begin
      n_errors++;
      $display("FAIL wr_pre_edge: got %0d expected 0", v);
    end
    tick();
    idle();
    rd_num = {3'd3, 3'd5, 3'd0, 3'd7};
    #1;
    n_checks++;
    if (rd_state !== 8'b11_10_01_00) begin
      n_errors++;
      $display("FAIL wr_multi_read: got %b expected 11100100", rd_state);
    end
    n_checks++;
    if (err !== 2'b01) begin
      n_errors++;
      $display("FAIL wr_out_of_range_err: got %b expected 01", err);
    end
  endtask

  task automatic test_collision();
    logic [SW-1:0] v;
    do_reset();
    set_wr(1, 2, 1);
    set_wr(3, 2, 3);
    tick();
    idle();
    read_thread(2, v);
    n_checks++;
    if (v !== 2'd1) begin
      n_errors++;
      $display("FAIL collision_value: got %0d expected 1", v);
    end
    n_checks++;
    if (err !== 2'b01) begin
      n_errors++;
      $display("FAIL collision_err: got %b expected 01", err);
    end
  endtask

  task automatic test_round_robin();
    logic [SW-1:0] v;
    int exp_num [3] = '{1, 4, 5};
    int exp_cnt [3] = '{3, 2, 1};
    do_reset();
    set_wr(0, 1, 2);
    set_wr(1, 4, 2);
    set_wr(2, 5, 2);
    scan_state  = 2'd2;
    claim_state = 2'd3;
    tick();
    idle();
    scan_en = 1'b1;
    for (int g = 0; g < 3; g++) begin
      tick();
      n_checks++;
      if (scan_valid !== 1'b1 || scan_num !== IW'(exp_num[g]) || cnt_match !== 4'(exp_cnt[g])) begin
        n_errors++;
        $display("FAIL rr_grant%0d: got valid=%b num=%0d cnt=%0d expected 1/%0d/%0d",
                 g, scan_valid, scan_num, cnt_match, exp_num[g], exp_cnt[g]);
      end
    end
    tick();
    n_checks++;
    if (scan_valid !== 1'b0 || scan_num !== 3'd5 || cnt_match !== 4'd0) begin
      n_errors++;
      $display("FAIL rr_exhausted: got valid=%b num=%0d cnt=%0d expected 0/5/0",
               scan_valid, scan_num, cnt_match);
    end
    scan_en = 1'b0;
    for (int g = 0; g < 3; g++) begin
      read_thread(exp_num[g], v);
      n_checks++;
      if (v !== 2'd3) begin
        n_errors++;
        $display("FAIL rr_claimed_t%0d: got %0d expected 3", exp_num[g], v);
      end
    end
  endtask

  // Continues from test_round_robin: rr_last is 5 here.
  task automatic test_wrap();
    set_wr(0, 0, 2);
    set_wr(1, 3, 2);
    tick();
    idle();
    scan_en = 1'b1;
    tick();
    n_checks++;
    if (scan_valid !== 1'b1 || scan_num !== 3'd0 || cnt_match !== 4'd2) begin
      n_errors++;
      $display("FAIL wrap_first: got valid=%b num=%0d cnt=%0d expected 1/0/2",
               scan_valid, scan_num, cnt_match);
    end
    tick();
    n_checks++;
    if (scan_valid !== 1'b1 || scan_num !== 3'd3 || cnt_match !== 4'd1) begin
      n_errors++;
      $display("FAIL wrap_second: got valid=%b num=%0d cnt=%0d expected 1/3/1",
               scan_valid, scan_num, cnt_match);
    end
    scan_en = 1'b0;
  endtask

  task automatic test_claim_collision();
    logic [SW-1:0] v;
    do_reset();
    set_wr(0, 4, 2);
    tick();
    idle();
    set_wr(0, 4, 1);
    scan_en     = 1'b1;
    scan_state  = 2'd2;
    claim_state = 2'd3;
    tick();
    idle();
    n_checks++;
    if (scan_valid !== 1'b1 || scan_num !== 3'd4) begin
      n_errors++;
      $display("FAIL claim_coll_grant: got valid=%b num=%0d expected 1/4", scan_valid, scan_num);
    end
    read_thread(4, v);
    n_checks++;
    if (v !== 2'd1) begin
      n_errors++;
      $display("FAIL claim_coll_value: got %0d expected 1", v);
    end
    n_checks++;
    if (err !== 2'b10) begin
      n_errors++;
      $display("FAIL claim_coll_err: got %b expected 10", err);
    end
  endtask

  task automatic test_claim_equal();
    int exp_num [3] = '{2, 3, 2};
    do_reset();
    set_wr(0, 2, 1);
    set_wr(1, 3, 1);
    tick();
    idle();
    scan_state  = 2'd1;
    claim_state = 2'd1;
    scan_en     = 1'b1;
    for (int g = 0; g < 3; g++) begin
      tick();
      n_checks++;
      if (scan_valid !== 1'b1 || scan_num !== IW'(exp_num[g])) begin
        n_errors++;
        $display("FAIL claim_equal%0d: got valid=%b num=%0d expected 1/%0d",
                 g, scan_valid, scan_num, exp_num[g]);
      end
    end
    scan_en = 1'b0;
    n_checks++;
    if (err !== 2'b00) begin
      n_errors++;
      $display("FAIL claim_equal_err: got %b expected 00", err);
    end
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] v;
    do_reset();
    set_wr(0, 1, 2);
    set_wr(1, 1, 2);
    set_wr(2, 4, 2);
    tick();
    idle();
    scan_en     = 1'b1;
    scan_state  = 2'd2;
    claim_state = 2'd3;
    tick();
    n_checks++;
    if (scan_valid !== 1'b1 || scan_num !== 3'd1 || err !== 2'b01) begin
      n_errors++;
      $display("FAIL mid_setup: got valid=%b num=%0d err=%b expected 1/1/01",
               scan_valid, scan_num, err);
    end
    set_wr(2, 5, 3);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    idle();
    n_checks++;
    if (scan_valid !== 1'b0 || err !== 2'b00 || scan_num !== 3'd0) begin
      n_errors++;
      $display("FAIL mid_reset_regs: got valid=%b err=%b num=%0d expected 0/00/0",
               scan_valid, err, scan_num);
    end
    for (int t = 0; t < NT; t++) begin
      read_thread(t, v);
      n_checks++;
      if (v !== 2'd0) begin
        n_errors++;
        $display("FAIL mid_reset_t%0d: got %0d expected 0", t, v);
      end
    end
    tick();
    set_wr(0, 0, 2);
    set_wr(1, 3, 2);
    tick();
    idle();
    scan_en = 1'b1;
    tick();
    scan_en = 1'b0;
    n_checks++;
    if (scan_valid !== 1'b1 || scan_num !== 3'd0) begin
      n_errors++;
      $display("FAIL mid_reset_rr_start: got valid=%b num=%0d expected 1/0", scan_valid, scan_num);
    end
  endtask

  initial begin
    RESET = 1'b0;
    idle();
    rd_num      = '0;
    scan_state  = '0;
    claim_state = '0;
    tick();
    test_reset();
    test_write_read();
    test_collision();
    test_round_robin();
    test_wrap();
    test_claim_collision();
    test_claim_equal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/thread_state_mc.md
Name: thread_state_mc

Overview:
- Parametrised multi-channel thread-state table; successor to the fixed 4-channel thread_state used inside the sha256crypt engine.
- Holds one STATE_WIDTH-bit state per thread.
- Any number of independent write/read channels (CPU, procb, memory, unit_input, …).
- New over the previous generation: a round-robin "scan-and-claim" port that atomically finds the next thread in a requested state and moves it to a new state. It replaces the external polling loops in process_bytes and core scheduling.

Parameters:
- N_THREADS, 6, number of threads (≥2, need not be a power of 2).
- N_THREADS_MSB, `MSB(N_THREADS-1), thread index MSB.
- N_CH, 4, number of write/read channels (1..8).
- STATE_WIDTH, 2, bits per state (`THREAD_STATE_MSB+1 in the engine build).
- STATE_RESET, 0, state loaded into every thread on reset (THREAD_STATE_NONE).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- wr_en  in  N_CH  per-channel write enable.
- wr_num  in  N_CH*(N_THREADS_MSB+1)  per-channel write thread index; channel k in slice k.
- wr_state  in  N_CH*STATE_WIDTH  per-channel new state.
- rd_num  in  N_CH*(N_THREADS_MSB+1)  per-channel read thread index.
- rd_state  out  N_CH*STATE_WIDTH  per-channel current state (asynchronous read).
- scan_en  in  1  request a scan this cycle.
- scan_state  in  STATE_WIDTH  state being searched for.
- claim_state  in  STATE_WIDTH  state written into the found thread.
- scan_valid  out  1  registered: previous-cycle scan found a thread.
- scan_num  out  N_THREADS_MSB+1  registered: index of the found/claimed thread.
- cnt_match  out  N_THREADS_MSB+2  registered: number of threads whose state equals scan_state (updated every cycle).
- err  out  2  sticky errors: [0] channel-vs-channel write collision, [1] channel-vs-claim collision.

Behaviour:
- Reset: all entries ← STATE_RESET; scan_valid=0, scan_num=0, cnt_match=0, err=0; round-robin pointer rr_last ← N_THREADS-1, so the first search starts at thread 0. RESET overrides every write and claim in the same cycle.
- Read: rd_state[k] = table[rd_num[k]] combinationally. It shows the pre-edge value; a write in cycle t is visible from t+1. rd_num ≥ N_THREADS returns 0.
- Write: on the edge, table[wr_num[k]] ← wr_state[k] for every k with wr_en[k].
  - Several enabled channels on the same thread: the lowest index k wins, err[0] ← 1.
  - Different threads in the same cycle all commit.
  - wr_num ≥ N_THREADS: ignored, err[0] ← 1.
- Scan, evaluated in cycle t on the pre-edge table:
  - match[i] = (table[i] == scan_state) for i < N_THREADS.
  - Search starts at (rr_last+1) mod N_THREADS and wraps past N_THREADS-1 to 0. The first match is F.
  - If scan_en and a match exists: at edge t+1, scan_valid=1, scan_num=F, rr_last ← F, and table[F] ← claim_state.
  - Otherwise scan_valid=0; scan_num and rr_last hold.
- Claim priority: a claim is lowest priority. If any wr_en channel writes F in the same cycle, the channel value wins, err[1] ← 1, and scan_valid is still 1; the consumer must treat it as lost only via err.
- Back-to-back scans: each cycle sees the previous cycle's claim, so the same thread is never granted twice without an intervening write back to scan_state.
- claim_state == scan_state is legal: the thread is re-granted only after the pointer wraps.
- cnt_match = popcount(match) of cycle t, registered at t+1, independent of scan_en.
- Latency: read 0 cycles, write 1, scan/claim 1, count 1.
- err bits remain set until RESET.

Decomposition:
- Shared header sha256.vh:
  - `MSB macro.
  - THREAD_STATE_* constants (NONE, WR, RDY, BUSY).
  - `THREAD_STATE_MSB.
- One sub-module, rr_pick_first:
  - Parametrised N-wide rotating priority encoder with inputs req vector and last index, outputs found and index.
  - Implemented as a doubled-vector mask plus a priority encoder.
  - Reusable by process_bytes and core arbitration.

Test Plan:
- Reset then read: RESET 1 cycle, then rd_num[0..3] = 0..3 → rd_state all 0, err=0, cnt_match=6 with scan_state=0.
- Collision: ch1 writes thread 2 ← 1 and ch3 writes thread 2 ← 3 in the same cycle → next cycle table[2]=1, err=2'b01.
- Round robin: threads 1, 4, 5 set to 2; scan_en=1 for 4 cycles with scan_state=2, claim_state=3.
  - Expected grants 1, 4, 5, then scan_valid=0.
  - Threads 1, 4, 5 then read 3; cnt_match steps 3→2→1→0.
- Wrap: rr_last=5; thread 0 and thread 3 in state 2; scan → grant 0 (wrap), next scan → 3.
- Claim collision: scan finds thread 4 while ch0 writes thread 4 ← 1 → scan_valid=1, scan_num=4, table[4]=1, err[1]=1.
- Reset mid-operation: RESET asserted with scan_en and wr_en active → scan_valid=0 next cycle, all entries 0, err cleared, next scan starts at thread 0.
